// File: rtl/duato_destport_decoder_pkg.sv
// Shared constants and types for the Duato destination-port decoder.
package duato_destport_decoder_pkg;

  // Output port count and port indices.
  localparam int unsigned P         = 5;
  localparam int unsigned PortLocal = 0;
  localparam int unsigned PortEast  = 1;
  localparam int unsigned PortNorth = 2;
  localparam int unsigned PortWest  = 3;
  localparam int unsigned PortSouth = 4;

  // Bit positions inside the encoded {x,y,a,b} destport.
  localparam int unsigned DpX = 3;
  localparam int unsigned DpY = 2;
  localparam int unsigned DpA = 1;
  localparam int unsigned DpB = 0;

  typedef logic [2:0] port_idx_t;

  typedef enum logic {
    StIdle = 1'b0,
    StBusy = 1'b1
  } state_e;

  // One-hot write vector for a port index.
  function automatic logic [P-1:0] port_onehot(port_idx_t p);
    return 5'b00001 << p;
  endfunction

endpackage

// File: rtl/duato_destport_decoder_credit_counter.sv
// Per-port downstream credit counter, saturating at B.
module duato_destport_decoder_credit_counter #(
  parameter int unsigned B = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       inc,
  input  logic       dec,
  output logic [3:0] count,
  output logic       nz,
  output logic       ovf
);

  localparam logic [3:0] BMax = 4'(B);

  logic [3:0] count_q, count_d;

  // Next count: simultaneous inc and dec cancel; inc at BMax saturates and flags ovf.
  always_comb begin
    count_d = count_q;
    ovf     = 1'b0;
    if (inc && !dec) begin
      if (count_q == BMax) begin
        ovf = 1'b1;
      end else begin
        count_d = count_q + 4'd1;
      end
    end else if (dec && !inc && (count_q != '0)) begin
      count_d = count_q - 4'd1;
    end
  end

  // Count register, reloaded to full depth on reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= BMax;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;
  assign nz    = |count_q;

endmodule

// File: rtl/duato_destport_decoder.sv
// Decodes {x,y,a,b} destports into an output port, picks the less-congested
// candidate for adaptive heads, holds it for the packet and forwards flits
// through one register stage as a one-hot port write.
module duato_destport_decoder
  import duato_destport_decoder_pkg::*;
#(
  parameter int unsigned FLIT_W = 32,
  parameter int unsigned B      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [FLIT_W-1:0] flit_in,
  input  logic              flit_in_head,
  input  logic              flit_in_tail,
  input  logic [3:0]        flit_in_destport,
  input  logic              flit_in_valid,
  output logic              flit_in_ready,
  output logic [FLIT_W-1:0] flit_out,
  output logic [P-1:0]      flit_out_wr,
  input  logic [P-1:0]      credit_in,
  output logic              pkt_err
);

  state_e            state_q, state_d;
  port_idx_t         lat_q, lat_d;
  logic [FLIT_W-1:0] flit_out_q;
  logic [P-1:0]      wr_q;
  logic              err_q;

  logic [3:0]        cred [P];
  logic [P-1:0]      cred_nz;
  logic [P-1:0]      cred_ovf;
  logic [P-1:0]      cred_dec;

  port_idx_t         cand_x, cand_y, sel;
  logic              fwd;
  port_idx_t         fwd_port;
  logic              err_set;

  for (genvar p = 0; p < P; p++) begin : g_cred
    duato_destport_decoder_credit_counter #(
      .B (B)
    ) u_cred (
      .clk   (clk),
      .reset (reset),
      .inc   (credit_in[p]),
      .dec   (cred_dec[p]),
      .count (cred[p]),
      .nz    (cred_nz[p]),
      .ovf   (cred_ovf[p])
    );
  end

  // Destport decode and candidate selection; credit ties favour the X candidate.
  always_comb begin
    cand_x = flit_in_destport[DpX] ? port_idx_t'(PortEast)  : port_idx_t'(PortWest);
    cand_y = flit_in_destport[DpY] ? port_idx_t'(PortNorth) : port_idx_t'(PortSouth);
    if (flit_in_destport[DpA] && flit_in_destport[DpB]) begin
      sel = (cred[cand_y] > cred[cand_x]) ? cand_y : cand_x;
    end else if (flit_in_destport[DpA]) begin
      sel = cand_x;
    end else if (flit_in_destport[DpB]) begin
      sel = cand_y;
    end else begin
      sel = port_idx_t'(PortLocal);
    end
  end

  // Packet FSM: ready, forwarding decision, port latch and protocol errors.
  always_comb begin
    state_d       = state_q;
    lat_d         = lat_q;
    flit_in_ready = 1'b0;
    fwd           = 1'b0;
    fwd_port      = lat_q;
    err_set       = 1'b0;
    case (state_q)
      StIdle: begin
        if (flit_in_head) begin
          flit_in_ready = cred_nz[sel];
          if (flit_in_valid && flit_in_ready) begin
            fwd      = 1'b1;
            fwd_port = sel;
            lat_d    = sel;
            if (!flit_in_tail) begin
              state_d = StBusy;
            end
          end
        end else begin
          // Stray body/tail outside a packet is swallowed and flagged.
          flit_in_ready = 1'b1;
          err_set       = flit_in_valid;
        end
      end
      StBusy: begin
        flit_in_ready = cred_nz[lat_q];
        if (flit_in_valid && flit_in_ready) begin
          fwd     = 1'b1;
          err_set = flit_in_head;
          if (flit_in_tail) begin
            state_d = StIdle;
          end
        end
      end
    endcase
    cred_dec = fwd ? port_onehot(fwd_port) : '0;
  end

  // State, latched port and registered output stage.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      lat_q      <= port_idx_t'(PortLocal);
      flit_out_q <= '0;
      wr_q       <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      lat_q   <= lat_d;
      wr_q    <= cred_dec;
      if (fwd) begin
        flit_out_q <= flit_in;
      end
      if (err_set || (|cred_ovf)) begin
        err_q <= 1'b1;
      end
    end
  end

  assign flit_out    = flit_out_q;
  assign flit_out_wr = wr_q;
  assign pkt_err     = err_q;

endmodule

// File: tb/tb_duato_destport_decoder.sv
// Self-checking bench for duato_destport_decoder with a behavioural model.
module tb_duato_destport_decoder;

  localparam int FW = 32;
  localparam int B  = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic [FW-1:0] flit_in;
  logic          flit_in_head, flit_in_tail, flit_in_valid;
  logic [3:0]    flit_in_destport;
  logic          flit_in_ready;
  logic [FW-1:0] flit_out;
  logic [4:0]    flit_out_wr;
  logic [4:0]    credit_in;
  logic          pkt_err;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  duato_destport_decoder #(
    .FLIT_W (FW),
    .B      (B)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .flit_in          (flit_in),
    .flit_in_head     (flit_in_head),
    .flit_in_tail     (flit_in_tail),
    .flit_in_destport (flit_in_destport),
    .flit_in_valid    (flit_in_valid),
    .flit_in_ready    (flit_in_ready),
    .flit_out         (flit_out),
    .flit_out_wr      (flit_out_wr),
    .credit_in        (credit_in),
    .pkt_err          (pkt_err)
  );

  always #5 clk = ~clk;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int          m_cred [5];
  bit          m_busy;
  int          m_lat;
  logic [31:0] m_out;
  logic [4:0]  m_wr;
  bit          m_err;

  // Port choice from the routing rules: list candidates, prefer more credits, X on tie.
  function automatic int m_sel(logic [3:0] dp);
    int cands[$];
    if (dp[1]) cands.push_back(dp[3] ? 1 : 3);
    if (dp[0]) cands.push_back(dp[2] ? 2 : 4);
    if (cands.size() == 0) return 0;
    if (cands.size() == 1) return cands[0];
    return (m_cred[cands[1]] > m_cred[cands[0]]) ? cands[1] : cands[0];
  endfunction

  function automatic bit m_ready();
    if (m_busy) return m_cred[m_lat] > 0;
    if (!flit_in_head) return 1'b1;
    return m_cred[m_sel(flit_in_destport)] > 0;
  endfunction

  always @(posedge clk) begin : model_b
    bit acc, fwd, inc, dec;
    int port;
    if (reset) begin
      foreach (m_cred[p]) m_cred[p] = B;
      m_busy = 0; m_lat = 0; m_out = '0; m_wr = '0; m_err = 0;
    end else begin
      acc  = flit_in_valid && m_ready();
      fwd  = 0;
      port = 0;
      if (acc) begin
        if (m_busy) begin
          fwd = 1; port = m_lat;
          if (flit_in_head) m_err = 1;
          if (flit_in_tail) m_busy = 0;
        end else if (flit_in_head) begin
          fwd = 1; port = m_sel(flit_in_destport);
          m_lat = port; m_busy = !flit_in_tail;
        end else begin
          m_err = 1;
        end
      end
      for (int p = 0; p < 5; p++) begin
        inc = credit_in[p];
        dec = fwd && (port == p);
        if (inc && !dec) begin
          if (m_cred[p] == B) m_err = 1;
          else m_cred[p]++;
        end else if (dec && !inc) begin
          m_cred[p]--;
        end
      end
      m_wr = fwd ? 5'(1 << port) : 5'b0;
      if (fwd) m_out = flit_in;
    end
  end

  // Compare DUT against the model every cycle, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      chk("cyc_ready", 32'(flit_in_ready), 32'(m_ready()));
      chk("cyc_wr", 32'(flit_out_wr), 32'(m_wr));
      chk("cyc_out", flit_out, m_out);
      chk("cyc_err", 32'(pkt_err), 32'(m_err));
    end
  end

  // ---------------- stimulus ----------------
  task automatic drive(bit v, bit h, bit t, logic [3:0] dp, logic [31:0] d, logic [4:0] cr);
    flit_in_valid = v; flit_in_head = h; flit_in_tail = t;
    flit_in_destport = dp; flit_in = d; credit_in = cr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    drive(0, 0, 0, 4'b0000, 32'h0, 5'b0);
    step();
    chk_en = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_out", flit_out, 32'h0);
    chk("rst_wr", 32'(flit_out_wr), 32'h0);
    chk("rst_err", 32'(pkt_err), 32'h0);

    // Single-flit packet to LOCAL.
    drive(1, 1, 1, 4'b0000, 32'hA1, 5'b0); step();
    chk("local_wr", 32'(flit_out_wr), 32'h01);
    chk("local_out", flit_out, 32'hA1);
    chk("local_cred_model", 32'(m_cred[0]), 32'd3);
    drive(0, 0, 0, 4'b0000, 32'h0, 5'b0); step();
    chk("idle_wr", 32'(flit_out_wr), 32'h0);
    chk("idle_hold", flit_out, 32'hA1);

    // Three-flit packet to EAST.
    drive(1, 1, 0, 4'b1010, 32'hB0, 5'b0); step();
    chk("east_h_wr", 32'(flit_out_wr), 32'h02);
    drive(1, 0, 0, 4'b0000, 32'hB1, 5'b0); step();
    chk("east_b_wr", 32'(flit_out_wr), 32'h02);
    drive(1, 0, 1, 4'b0000, 32'hB2, 5'b0); step();
    chk("east_t_wr", 32'(flit_out_wr), 32'h02);
    chk("east_t_out", flit_out, 32'hB2);
    chk("east_cred_model", 32'(m_cred[1]), 32'd1);
    chk("east_idle_model", 32'(m_busy), 32'd0);

    // Adaptive selection: NORTH=3 vs EAST=1, then a tie.
    drive(1, 1, 1, 4'b0101, 32'hC0, 5'b0); step();
    chk("north_wr", 32'(flit_out_wr), 32'h04);
    drive(1, 1, 1, 4'b1111, 32'hC1, 5'b0); step();
    chk("adapt_north_wr", 32'(flit_out_wr), 32'h04);
    drive(0, 0, 0, 4'b0000, 32'h0, 5'b00010); step();
    drive(1, 1, 1, 4'b1111, 32'hC2, 5'b0); step();
    chk("adapt_tie_east_wr", 32'(flit_out_wr), 32'h02);

    // Drain SOUTH and stall, then credit return and same-cycle accept+return.
    drive(1, 1, 0, 4'b0001, 32'hD0, 5'b0); step();
    chk("south_h_wr", 32'(flit_out_wr), 32'h10);
    for (int i = 1; i < 4; i++) begin
      drive(1, 0, 0, 4'b0000, 32'hD0 + 32'(i), 5'b0); step();
      chk("south_b_wr", 32'(flit_out_wr), 32'h10);
    end
    drive(1, 0, 0, 4'b0000, 32'hD4, 5'b0); #1;
    chk("south_stall_ready", 32'(flit_in_ready), 32'h0);
    step();
    chk("south_stall_wr", 32'(flit_out_wr), 32'h0);
    drive(1, 0, 0, 4'b0000, 32'hD4, 5'b10000); #1;
    chk("south_pulse_ready", 32'(flit_in_ready), 32'h0);
    step();
    chk("south_pulse_wr", 32'(flit_out_wr), 32'h0);
    drive(1, 0, 0, 4'b0000, 32'hD4, 5'b10000); #1;
    chk("south_after_pulse_ready", 32'(flit_in_ready), 32'h1);
    step();
    chk("south_acc_wr", 32'(flit_out_wr), 32'h10);
    chk("south_acc_out", flit_out, 32'hD4);
    chk("south_same_cycle_model", 32'(m_cred[4]), 32'd1);
    drive(1, 0, 1, 4'b0000, 32'hD5, 5'b0); step();
    chk("south_tail_wr", 32'(flit_out_wr), 32'h10);
    for (int i = 0; i < 4; i++) begin
      drive(0, 0, 0, 4'b0000, 32'h0, 5'b10000); step();
    end

    // Body flit while idle is dropped and flagged.
    drive(1, 0, 0, 4'b0000, 32'hE0, 5'b0); step();
    chk("stray_wr", 32'(flit_out_wr), 32'h0);
    chk("stray_hold", flit_out, 32'hD5);
    chk("stray_err", 32'(pkt_err), 32'h1);

    // Reset mid-packet to WEST.
    drive(1, 1, 0, 4'b0010, 32'hF0, 5'b0); step();
    chk("west_h_wr", 32'(flit_out_wr), 32'h08);
    drive(1, 0, 0, 4'b0000, 32'hF1, 5'b0); step();
    drive(0, 0, 0, 4'b0000, 32'h0, 5'b0);
    reset = 1'b1; step(); reset = 1'b0;
    chk("abort_wr", 32'(flit_out_wr), 32'h0);
    chk("abort_out", flit_out, 32'h0);
    chk("abort_err", 32'(pkt_err), 32'h0);
    chk("abort_idle_model", 32'(m_busy), 32'd0);
    chk("abort_cred_model", 32'(m_cred[3]), 32'd4);
    drive(1, 1, 1, 4'b0101, 32'h60, 5'b0); step();
    chk("post_abort_wr", 32'(flit_out_wr), 32'h04);

    // Credit return at full depth saturates and flags.
    drive(0, 0, 0, 4'b0000, 32'h0, 5'b00010); step();
    chk("ovf_err", 32'(pkt_err), 32'h1);
    chk("ovf_cred_model", 32'(m_cred[1]), 32'd4);

    // Mixed traffic, checked cycle by cycle against the model.
    for (int i = 0; i < 80; i++) begin
      drive(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
            4'($urandom), $urandom, 5'($urandom & $urandom));
      step();
    end
    drive(0, 0, 0, 4'b0000, 32'h0, 5'b0); step();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/duato_destport_decoder.md
# duato_destport_decoder

Output-side counterpart of the mesh Duato routing function. It receives flits together with the 4-bit encoded destination port `{x,y,a,b}` produced upstream and decodes it into candidate output ports. For adaptive (two-candidate) packets it selects the less-congested port, and it tracks downstream credits per port. It holds the chosen port for the whole packet and forwards flits through one registered stage as a one-hot port write. It sits between the input buffer and the crossbar of one router input.

## Interface
Parameters:
- `FLIT_W`, 32, flit payload width.
- `B`, 4, downstream buffer depth per output port (initial and maximum credit count); legal range 1..15.

Ports:
- `clk`  in  1  clock.
- `reset`  in  1  synchronous, active-high reset.
- `flit_in`  in  FLIT_W  incoming flit payload.
- `flit_in_head`  in  1  flit is a packet head.
- `flit_in_tail`  in  1  flit is a packet tail (head+tail = single-flit packet).
- `flit_in_destport`  in  4  encoded `{x,y,a,b}`, valid with head flits only.
- `flit_in_valid`  in  1  flit presented.
- `flit_in_ready`  out  1  flit accepted this cycle when valid & ready.
- `flit_out`  out  FLIT_W  registered flit payload.
- `flit_out_wr`  out  5  one-hot output port write: [0]LOCAL, [1]EAST, [2]NORTH, [3]WEST, [4]SOUTH.
- `credit_in`  in  5  per-port credit return pulse, one credit per bit per cycle.
- `pkt_err`  out  1  sticky protocol-error flag.

## Operation
- Decode of `{x,y,a,b}`:
  - `a=0,b=0` → LOCAL, regardless of x and y.
  - `a=1` → X candidate: EAST if x=1, else WEST.
  - `b=1` → Y candidate: NORTH if y=1, else SOUTH.
- Selection:
  - One candidate → use it.
  - Two candidates → use the one with the larger credit count.
  - Credit tie → X candidate.
- Credits: one 4-bit counter per port, reset to B.
  - Decrement when a flit is accepted for that port.
  - Increment on `credit_in[p]`.
  - Accept and credit return on the same port in the same cycle → counter unchanged.
  - Increment at B → counter saturates at B and `pkt_err` is set.
- FSM, states IDLE and BUSY:
  - IDLE:
    - `flit_in_ready` = credit[selected] > 0, where selected comes from the current decode.
    - Accepted head latches the selected port; go to BUSY unless tail is also set.
    - Valid non-head flit → accepted (ready=1) and dropped, no output, `pkt_err` set.
  - BUSY:
    - `flit_in_ready` = credit[latched] > 0.
    - Flits are forwarded to the latched port.
    - Accepted tail → IDLE.
    - Head flit arriving in BUSY is forwarded as body and sets `pkt_err`; its destport is ignored.
- The selection for two-candidate heads samples credits in the acceptance cycle only. It is never re-evaluated mid-packet.
- `pkt_err` clears only on reset.

## Timing
- Reset values:
  - `flit_out`=0, `flit_out_wr`=0, `pkt_err`=0.
  - State IDLE, all credits = B.
- `flit_in_ready` is combinational from state, credits and `flit_in_destport`. It does not depend on `flit_in_valid`.
- Latency: flit accepted at edge N → `flit_out`/`flit_out_wr` valid from edge N to N+1, one cycle.
  - `flit_out_wr` is 0 in any cycle following no acceptance.
  - `flit_out` holds its last value when no flit is accepted.
- Throughput: one flit per cycle while credits allow.
  - With B=1, back-to-back flits on the same port require a `credit_in` pulse. A pulse in cycle N allows acceptance in cycle N+1.
- Reset during BUSY aborts the packet: next cycle state is IDLE and credits are B.

## Structure
- Shared package: port index constants (LOCAL=0, EAST=1, NORTH=2, WEST=3, SOUTH=4), P=5, destport bit positions (x=3, y=2, a=1, b=0), FSM state encoding.
- Sub-module `credit_counter`:
  - Parameter B.
  - Inputs: inc, dec.
  - Outputs: count, `nz`, `ovf`.
  - Instantiated five times.
- Decode, selection and FSM stay in the top module.

## Test plan
- Reset, then single-flit packet with head+tail, destport 4'b0000 → `flit_out_wr`=5'b00001 one cycle later; LOCAL credit B→B-1.
- Head destport 4'b1010 (EAST only), 3-flit packet, B=4, no returns → three consecutive writes 5'b00010; EAST credit 1; state IDLE after tail.
- Head destport 4'b1111 with EAST=1 and NORTH=3 credits → NORTH (5'b00100) chosen. Repeat with equal credits → EAST chosen.
- B=1, 2-flit packet to SOUTH (4'b0001):
  - Second flit stalls with ready=0.
  - `credit_in[4]` pulse → flit accepted the next cycle.
  - Same-cycle accept plus credit → count unchanged.
- Body flit while IDLE → dropped, no write, `pkt_err`=1. `credit_in[1]` with EAST at B → count stays B, `pkt_err`=1.
- `reset` asserted mid-packet (BUSY, WEST credit 2) → next cycle IDLE, all credits 4, outputs 0. New head is routed per its own destport.
